// File: rtl/uart_core_cfg_if.sv
// Host-side bundle for uart_core_cfg.
// Purpose: groups the TX valid/ready handshake and the RX result signals so
//          that the byte engine and the host logic connect through one port.
// Signals:
//   tx_valid, tx_data      host -> core  TX payload offer
//   tx_ready               core -> host  core idle and able to take a payload
//   rx_valid               core -> host  one-cycle pulse, frame received
//   rx_data                core -> host  received payload, held until next rx_valid
//   rx_parity_err          core -> host  parity mismatch, qualified by rx_valid
//   rx_frame_err           core -> host  stop bit sampled low, qualified by rx_valid
// Modports: master = host logic, slave = uart_core_cfg.
interface uart_core_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_err;
  logic                 rx_frame_err;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, rx_valid, rx_data, rx_parity_err, rx_frame_err
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, rx_valid, rx_data, rx_parity_err, rx_frame_err
  );
endinterface

// File: rtl/uart_core_cfg.sv
// uart_core_cfg: parametrised full-duplex UART byte engine.
// Purpose: serialises host payloads onto uart_tx (valid/ready handshake) and
//          deserialises uart_rx frames with synchronisation, start-bit glitch
//          rejection and parity/framing error reporting. TX and RX are
//          fully independent.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   bus      slave modport of uart_core_cfg_if (TX handshake, RX results)
//   uart_tx  out  serial line out, idle high, registered
//   uart_rx  in   serial line in, asynchronous to clk
module uart_core_cfg #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  uart_core_cfg_if.slave bus,
  output logic           uart_tx,
  input  logic           uart_rx
);

  localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
  localparam int HALF    = BIT_CYC / 2;
  localparam int CNT_W   = $clog2(BIT_CYC + 1);
  localparam int IDX_W   = 4;
  localparam logic [CNT_W-1:0] BIT_MAX   = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  // Parameter legality is enforced at elaboration time.
  if (BIT_CYC < 4) begin : g_bad_baud
    $error("uart_core_cfg: CLK_FREQ/BAUD_RATE must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_core_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_core_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_core_cfg: STOP_BITS must be 1 or 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_core_cfg: SYNC_STAGES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_e;

  // Parity bit for a payload: even parity is the plain XOR, odd is its inverse.
  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // ---------------------------------------------------------------- TX ----
  state_e               tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
  logic                 tx_par_q, tx_par_d;
  logic                 uart_tx_q, uart_tx_d;
  logic                 tx_ready_q, tx_ready_d;

  // TX next-state: uart_tx_d is the line level for the state being entered,
  // so the registered line changes exactly at each bit boundary.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_ONE;
    tx_idx_d   = tx_idx_q;
    tx_shreg_d = tx_shreg_q;
    tx_par_d   = tx_par_q;
    uart_tx_d  = uart_tx_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d  = {CNT_W{1'b0}};
        tx_idx_d  = {IDX_W{1'b0}};
        uart_tx_d = 1'b1;
        if (bus.tx_valid && tx_ready_q) begin
          tx_state_d = S_START;
          tx_shreg_d = bus.tx_data;
          tx_par_d   = par_bit(bus.tx_data);
          uart_tx_d  = 1'b0;
        end else begin
          tx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_MAX) begin
          tx_cnt_d   = {CNT_W{1'b0}};
          tx_state_d = S_DATA;
          uart_tx_d  = tx_shreg_q[0];
        end else begin
          tx_state_d = S_START;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_MAX) begin
          tx_cnt_d = {CNT_W{1'b0}};
          if (tx_idx_q == DATA_LAST) begin
            tx_idx_d = {IDX_W{1'b0}};
            if (PARITY != 0) begin
              tx_state_d = S_PAR;
              uart_tx_d  = tx_par_q;
            end else begin
              tx_state_d = S_STOP;
              uart_tx_d  = 1'b1;
            end
          end else begin
            tx_idx_d   = tx_idx_q + IDX_ONE;
            tx_shreg_d = {1'b0, tx_shreg_q[DATA_BITS-1:1]};
            uart_tx_d  = tx_shreg_q[1];
          end
        end else begin
          tx_state_d = S_DATA;
        end
      end
      S_PAR: begin
        if (tx_cnt_q == BIT_MAX) begin
          tx_cnt_d   = {CNT_W{1'b0}};
          tx_state_d = S_STOP;
          uart_tx_d  = 1'b1;
        end else begin
          tx_state_d = S_PAR;
        end
      end
      S_STOP: begin
        uart_tx_d = 1'b1;
        if (tx_cnt_q == BIT_MAX) begin
          tx_cnt_d = {CNT_W{1'b0}};
          if (tx_idx_q == STOP_LAST) begin
            tx_state_d = S_IDLE;
          end else begin
            tx_idx_d = tx_idx_q + IDX_ONE;
          end
        end else begin
          tx_state_d = S_STOP;
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_cnt_d   = {CNT_W{1'b0}};
        uart_tx_d  = 1'b1;
      end
    endcase
    tx_ready_d = (tx_state_d == S_IDLE);
  end

  // TX state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= {CNT_W{1'b0}};
      tx_idx_q   <= {IDX_W{1'b0}};
      tx_shreg_q <= {DATA_BITS{1'b0}};
      tx_par_q   <= 1'b0;
      uart_tx_q  <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shreg_q <= tx_shreg_d;
      tx_par_q   <= tx_par_d;
      uart_tx_q  <= uart_tx_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign uart_tx      = uart_tx_q;
  assign bus.tx_ready = tx_ready_q;

  // ---------------------------------------------------------------- RX ----
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   rxs_prev_q;
  state_e                 rx_state_q, rx_state_d;
  logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]       rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0]   rx_shreg_q, rx_shreg_d;
  logic                   rx_perr_acc_q, rx_perr_acc_d;
  logic                   rx_ferr_acc_q, rx_ferr_acc_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_perr_q, rx_perr_d;
  logic                   rx_ferr_q, rx_ferr_d;

  assign rxs = sync_q[SYNC_STAGES-1];

  // RX next-state. Only a 1->0 step of rxs starts a frame, so a line held
  // low after a framing error cannot retrigger until it has gone high again.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q + CNT_ONE;
    rx_idx_d      = rx_idx_q;
    rx_shreg_d    = rx_shreg_q;
    rx_perr_acc_d = rx_perr_acc_q;
    rx_ferr_acc_d = rx_ferr_acc_q;
    rx_valid_d    = 1'b0;
    rx_data_d     = rx_data_q;
    rx_perr_d     = rx_perr_q;
    rx_ferr_d     = rx_ferr_q;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = {CNT_W{1'b0}};
        if (rxs_prev_q && !rxs) begin
          // The edge cycle itself counts as cycle 0 of the start bit.
          rx_state_d    = S_START;
          rx_cnt_d      = CNT_ONE;
          rx_idx_d      = {IDX_W{1'b0}};
          rx_perr_acc_d = 1'b0;
          rx_ferr_acc_d = 1'b0;
        end else begin
          rx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_CNT) begin
          rx_cnt_d = {CNT_W{1'b0}};
          if (rxs) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_state_d = S_DATA;
          end
        end else begin
          rx_state_d = S_START;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_MAX) begin
          rx_cnt_d   = {CNT_W{1'b0}};
          rx_shreg_d = {rxs, rx_shreg_q[DATA_BITS-1:1]};
          if (rx_idx_q == DATA_LAST) begin
            rx_idx_d = {IDX_W{1'b0}};
            if (PARITY != 0) begin
              rx_state_d = S_PAR;
            end else begin
              rx_state_d = S_STOP;
            end
          end else begin
            rx_idx_d = rx_idx_q + IDX_ONE;
          end
        end else begin
          rx_state_d = S_DATA;
        end
      end
      S_PAR: begin
        if (rx_cnt_q == BIT_MAX) begin
          rx_cnt_d      = {CNT_W{1'b0}};
          rx_perr_acc_d = rxs ^ par_bit(rx_shreg_q);
          rx_state_d    = S_STOP;
        end else begin
          rx_state_d = S_PAR;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_MAX) begin
          rx_cnt_d      = {CNT_W{1'b0}};
          rx_ferr_acc_d = rx_ferr_acc_q | ~rxs;
          if (rx_idx_q == STOP_LAST) begin
            // Deliver now, mid stop bit, so the next start edge is not missed.
            rx_state_d = S_IDLE;
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shreg_q;
            rx_perr_d  = rx_perr_acc_q;
            rx_ferr_d  = rx_ferr_acc_q | ~rxs;
          end else begin
            rx_idx_d = rx_idx_q + IDX_ONE;
          end
        end else begin
          rx_state_d = S_STOP;
        end
      end
      default: begin
        rx_state_d = S_IDLE;
        rx_cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // RX synchroniser, edge history, state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= {SYNC_STAGES{1'b1}};
      rxs_prev_q    <= 1'b1;
      rx_state_q    <= S_IDLE;
      rx_cnt_q      <= {CNT_W{1'b0}};
      rx_idx_q      <= {IDX_W{1'b0}};
      rx_shreg_q    <= {DATA_BITS{1'b0}};
      rx_perr_acc_q <= 1'b0;
      rx_ferr_acc_q <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= {DATA_BITS{1'b0}};
      rx_perr_q     <= 1'b0;
      rx_ferr_q     <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], uart_rx};
      rxs_prev_q    <= rxs;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_idx_q      <= rx_idx_d;
      rx_shreg_q    <= rx_shreg_d;
      rx_perr_acc_q <= rx_perr_acc_d;
      rx_ferr_acc_q <= rx_ferr_acc_d;
      rx_valid_q    <= rx_valid_d;
      rx_data_q     <= rx_data_d;
      rx_perr_q     <= rx_perr_d;
      rx_ferr_q     <= rx_ferr_d;
    end
  end

  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_data       = rx_data_q;
  assign bus.rx_parity_err = rx_perr_q;
  assign bus.rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_core_cfg.sv
// Testbench for uart_core_cfg. Three instances share clk/rst:
//   a: 8N1, uart_rx driven by the bench or looped from its own uart_tx
//   b: 7E2, uart_tx looped straight into uart_rx
//   c: 8O1, uart_rx driven by the bench
// All use BIT_CYC = 1_600_000 / 100_000 = 16.
module tb_uart_core_cfg;
  localparam int CF = 1_600_000;
  localparam int BR = 100_000;
  localparam int BC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_core_cfg_if #(.DATA_BITS(8)) bus_a ();
  uart_core_cfg_if #(.DATA_BITS(7)) bus_b ();
  uart_core_cfg_if #(.DATA_BITS(8)) bus_c ();

  logic uart_tx_a, uart_tx_b, uart_tx_c;
  logic rx_a = 1'b1;
  logic rx_c = 1'b1;
  logic loop_a = 1'b0;
  logic rx_in_a;
  assign rx_in_a = loop_a ? uart_tx_a : rx_a;

  uart_core_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .uart_tx(uart_tx_a), .uart_rx(rx_in_a));
  uart_core_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .uart_tx(uart_tx_b), .uart_rx(uart_tx_b));
  uart_core_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .SYNC_STAGES(3)) u_c (
    .clk(clk), .rst(rst), .bus(bus_c.slave), .uart_tx(uart_tx_c), .uart_rx(rx_c));

  always #5 clk = ~clk;

  // Received-frame logs, one per instance, filled on the falling edge.
  int cnt_a = 0, cnt_b = 0, cnt_c = 0;
  logic [7:0] a_data [0:7];
  logic       a_perr [0:7];
  logic       a_ferr [0:7];
  logic [6:0] b_data [0:7];
  logic       b_perr [0:7];
  logic       b_ferr [0:7];
  logic [7:0] c_data [0:7];
  logic       c_perr [0:7];
  logic       c_ferr [0:7];

  always @(negedge clk) begin
    if (bus_a.rx_valid) begin
      a_data[cnt_a[2:0]] <= bus_a.rx_data;
      a_perr[cnt_a[2:0]] <= bus_a.rx_parity_err;
      a_ferr[cnt_a[2:0]] <= bus_a.rx_frame_err;
      cnt_a <= cnt_a + 1;
    end
    if (bus_b.rx_valid) begin
      b_data[cnt_b[2:0]] <= bus_b.rx_data;
      b_perr[cnt_b[2:0]] <= bus_b.rx_parity_err;
      b_ferr[cnt_b[2:0]] <= bus_b.rx_frame_err;
      cnt_b <= cnt_b + 1;
    end
    if (bus_c.rx_valid) begin
      c_data[cnt_c[2:0]] <= bus_c.rx_data;
      c_perr[cnt_c[2:0]] <= bus_c.rx_parity_err;
      c_ferr[cnt_c[2:0]] <= bus_c.rx_frame_err;
      cnt_c <= cnt_c + 1;
    end
  end

  task automatic line_a(input logic b, input int n);
    rx_a = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic line_c(input logic b, input int n);
    rx_c = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_a(input logic [7:0] d, input logic stop);
    line_a(1'b0, BC);
    for (int k = 0; k < 8; k++) line_a(d[k], BC);
    line_a(stop, BC);
  endtask

  task automatic frame_c(input logic [7:0] d, input logic par, input logic stop);
    line_c(1'b0, BC);
    for (int k = 0; k < 8; k++) line_c(d[k], BC);
    line_c(par, BC);
    line_c(stop, BC);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (bus_a.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", bus_a.tx_ready); end
    n_tests++; if (uart_tx_a !== 1'b1) begin n_fail++; $display("FAIL reset_uart_tx: got %b want 1", uart_tx_a); end
    n_tests++; if (bus_a.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", bus_a.rx_valid); end
    n_tests++; if (bus_a.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", bus_a.rx_data); end
    n_tests++; if (bus_a.rx_parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", bus_a.rx_parity_err); end
    n_tests++; if (bus_a.rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", bus_a.rx_frame_err); end
    n_tests++; if (bus_b.tx_ready !== 1'b1 || uart_tx_b !== 1'b1) begin n_fail++; $display("FAIL reset_b_tx: got ready=%b line=%b want 1/1", bus_b.tx_ready, uart_tx_b); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_tx_a5();
    logic [9:0] frame;
    int bad, rdy_bad;
    frame   = {1'b1, 8'hA5, 1'b0};
    rdy_bad = 0;
    bus_a.tx_data  = 8'hA5;
    bus_a.tx_valid = 1'b1;
    @(negedge clk);
    bus_a.tx_valid = 1'b0;
    bus_a.tx_data  = 8'h00;   // must not disturb the frame in flight
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < BC; c++) begin
        if (uart_tx_a !== frame[b]) bad++;
        if (bus_a.tx_ready !== 1'b0) rdy_bad++;
        if (b == 4 && c == 0) bus_a.tx_valid = 1'b1;  // offered while busy
        if (b == 4 && c == 1) bus_a.tx_valid = 1'b0;
        @(negedge clk);
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL tx_bit%0d: %0d of 16 cycles wrong, want line %b", b, bad, frame[b]); end
    end
    n_tests++; if (rdy_bad != 0) begin n_fail++; $display("FAIL tx_ready_low: high in %0d of 160 frame cycles, want 0", rdy_bad); end
    n_tests++; if (bus_a.tx_ready !== 1'b1 || uart_tx_a !== 1'b1) begin n_fail++; $display("FAIL tx_after_frame: ready=%b line=%b want 1/1", bus_a.tx_ready, uart_tx_a); end
    repeat (20) @(negedge clk);
    n_tests++; if (uart_tx_a !== 1'b1 || bus_a.tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ignored_offer: ready=%b line=%b want idle 1/1", bus_a.tx_ready, uart_tx_a); end
  endtask

  task automatic test_back_to_back();
    int t0, t1, base;
    logic prev, line_at_t1;
    t0 = -1; t1 = -1; line_at_t1 = 1'b1;
    base = cnt_b;
    prev = bus_b.tx_ready;
    bus_b.tx_data  = 7'h55;
    bus_b.tx_valid = 1'b1;
    for (int i = 1; i <= 420; i++) begin
      @(negedge clk);
      if (i == 1) bus_b.tx_data = 7'h03;
      if (prev && !bus_b.tx_ready) begin
        if (t0 < 0) t0 = i;
        else if (t1 < 0) begin
          t1 = i;
          line_at_t1 = uart_tx_b;
          bus_b.tx_valid = 1'b0;
        end
      end
      prev = bus_b.tx_ready;
    end
    bus_b.tx_valid = 1'b0;
    n_tests++; if (t0 < 0 || t1 < 0 || (t1 - t0) != 177) begin n_fail++; $display("FAIL b2b_spacing: starts at %0d and %0d, want 177 apart", t0, t1); end
    n_tests++; if (line_at_t1 !== 1'b0) begin n_fail++; $display("FAIL b2b_start_bit: line %b want 0", line_at_t1); end
    n_tests++; if (cnt_b - base != 2) begin n_fail++; $display("FAIL b2b_rx_count: got %0d want 2", cnt_b - base); end
    n_tests++; if (b_data[base % 8] !== 7'h55) begin n_fail++; $display("FAIL b2b_rx_data0: got %h want 55", b_data[base % 8]); end
    n_tests++; if (b_data[(base + 1) % 8] !== 7'h03) begin n_fail++; $display("FAIL b2b_rx_data1: got %h want 03", b_data[(base + 1) % 8]); end
    n_tests++; if ({b_perr[base % 8], b_ferr[base % 8], b_perr[(base + 1) % 8], b_ferr[(base + 1) % 8]} !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_errs: perr/ferr %b%b %b%b want 00 00", b_perr[base % 8], b_ferr[base % 8], b_perr[(base + 1) % 8], b_ferr[(base + 1) % 8]);
    end
  endtask

  task automatic test_parity_err();
    int base;
    base = cnt_c;
    frame_c(8'h00, 1'b0, 1'b1);   // odd parity wants 1 here
    line_c(1'b1, 40);
    n_tests++; if (cnt_c - base != 1) begin n_fail++; $display("FAIL par_count: got %0d want 1", cnt_c - base); end
    n_tests++; if (c_data[base % 8] !== 8'h00 || c_perr[base % 8] !== 1'b1 || c_ferr[base % 8] !== 1'b0) begin
      n_fail++; $display("FAIL par_bad: data=%h perr=%b ferr=%b want 00/1/0", c_data[base % 8], c_perr[base % 8], c_ferr[base % 8]);
    end
    frame_c(8'h01, 1'b0, 1'b1);   // one set bit: odd parity bit is 0
    line_c(1'b1, 40);
    n_tests++; if (cnt_c - base != 2 || c_data[(base + 1) % 8] !== 8'h01 || c_perr[(base + 1) % 8] !== 1'b0) begin
      n_fail++; $display("FAIL par_good: count=%0d data=%h perr=%b want 2/01/0", cnt_c - base, c_data[(base + 1) % 8], c_perr[(base + 1) % 8]);
    end
  endtask

  task automatic test_frame_err();
    int base;
    base = cnt_a;
    frame_a(8'hFF, 1'b0);
    line_a(1'b0, 40 * BC);
    line_a(1'b1, 50);
    n_tests++; if (cnt_a - base != 1) begin n_fail++; $display("FAIL break_count: got %0d want 1", cnt_a - base); end
    n_tests++; if (a_data[base % 8] !== 8'hFF || a_ferr[base % 8] !== 1'b1 || a_perr[base % 8] !== 1'b0) begin
      n_fail++; $display("FAIL break_frame: data=%h ferr=%b perr=%b want FF/1/0", a_data[base % 8], a_ferr[base % 8], a_perr[base % 8]);
    end
    frame_a(8'h5A, 1'b1);
    line_a(1'b1, 40);
    n_tests++; if (cnt_a - base != 2 || a_data[(base + 1) % 8] !== 8'h5A || a_ferr[(base + 1) % 8] !== 1'b0) begin
      n_fail++; $display("FAIL break_recover: count=%0d data=%h ferr=%b want 2/5A/0", cnt_a - base, a_data[(base + 1) % 8], a_ferr[(base + 1) % 8]);
    end
  endtask

  task automatic test_glitch();
    int base;
    base = cnt_a;
    line_a(1'b0, 5);
    line_a(1'b1, 20);
    n_tests++; if (cnt_a != base) begin n_fail++; $display("FAIL glitch_reject: got %0d frames want 0", cnt_a - base); end
    frame_a(8'h3C, 1'b1);
    line_a(1'b1, 40);
    n_tests++; if (cnt_a - base != 1 || a_data[base % 8] !== 8'h3C || a_ferr[base % 8] !== 1'b0) begin
      n_fail++; $display("FAIL glitch_then_frame: count=%0d data=%h ferr=%b want 1/3C/0", cnt_a - base, a_data[base % 8], a_ferr[base % 8]);
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    loop_a = 1'b0;
    base = cnt_a;
    bus_a.tx_data  = 8'h00;
    bus_a.tx_valid = 1'b1;
    rx_a = 1'b0;
    @(negedge clk);
    bus_a.tx_valid = 1'b0;
    repeat (49) @(negedge clk);
    n_tests++; if (uart_tx_a !== 1'b0 || bus_a.tx_ready !== 1'b0) begin n_fail++; $display("FAIL midframe_busy: line=%b ready=%b want 0/0", uart_tx_a, bus_a.tx_ready); end
    rst = 1'b1;
    #1;
    n_tests++; if (uart_tx_a !== 1'b1 || bus_a.tx_ready !== 1'b1) begin n_fail++; $display("FAIL midframe_reset: line=%b ready=%b want 1/1", uart_tx_a, bus_a.tx_ready); end
    @(negedge clk);
    rx_a = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    n_tests++; if (cnt_a != base) begin n_fail++; $display("FAIL midframe_no_rx: got %0d frames want 0", cnt_a - base); end
    loop_a = 1'b1;
    bus_a.tx_data  = 8'h81;
    bus_a.tx_valid = 1'b1;
    @(negedge clk);
    bus_a.tx_valid = 1'b0;
    repeat (220) @(negedge clk);
    n_tests++; if (cnt_a - base != 1 || a_data[base % 8] !== 8'h81 || a_perr[base % 8] !== 1'b0 || a_ferr[base % 8] !== 1'b0) begin
      n_fail++; $display("FAIL midframe_after: count=%0d data=%h perr=%b ferr=%b want 1/81/0/0", cnt_a - base, a_data[base % 8], a_perr[base % 8], a_ferr[base % 8]);
    end
    n_tests++; if (bus_a.tx_ready !== 1'b1) begin n_fail++; $display("FAIL midframe_ready: got %b want 1", bus_a.tx_ready); end
    loop_a = 1'b0;
  endtask

  initial begin
    bus_a.tx_valid = 1'b0; bus_a.tx_data = 8'h00;
    bus_b.tx_valid = 1'b0; bus_b.tx_data = 7'h00;
    bus_c.tx_valid = 1'b0; bus_c.tx_data = 8'h00;
    test_reset();
    test_tx_a5();
    test_back_to_back();
    test_parity_err();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_core_cfg.md
Name: uart_core_cfg

Overview:
- Parametrised full-duplex UART byte engine; next generation of the fixed 8N1 UART byte block.
- Configurable data width, parity, stop bits, baud divisor.
- TX side uses a valid/ready handshake in place of edge-triggered starts.
- RX side adds a metastability synchroniser, start-bit glitch rejection, and parity/framing error reporting.
- Sits between host-link logic (command decoder / FIFO) and the board UART pins.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, line rate in baud
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame, legal 1 or 2
SYNC_STAGES, 2, uart_rx synchroniser depth, legal >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
tx_valid  in  1  TX payload valid
tx_data  in  DATA_BITS  TX payload, LSB sent first
tx_ready  out  1  TX idle and able to accept a payload
uart_tx  out  1  serial line out, idle high
uart_rx  in  1  serial line in, asynchronous
rx_valid  out  1  one-cycle pulse: frame received
rx_data  out  DATA_BITS  received payload, held until next rx_valid
rx_parity_err  out  1  parity mismatch on the frame, qualified by rx_valid
rx_frame_err  out  1  a stop bit sampled low, qualified by rx_valid

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- BIT_CYC = CLK_FREQ/BAUD_RATE (integer division), HALF = BIT_CYC/2.
- Counter width is $clog2(BIT_CYC+1). Elaboration fails if BIT_CYC < 4 or a parameter is out of range.
- Reset values: tx_ready=1, uart_tx=1, rx_valid=0, rx_data=0, rx_parity_err=0, rx_frame_err=0. Both FSMs go to IDLE and counters clear.
- Synchroniser flops reset to 1.
- Reset asserted mid-frame aborts immediately:
  - uart_tx returns high.
  - No rx_valid is produced for the partial frame.
- TX FSM states: IDLE, START, DATA, PAR, STOP.
  - Handshake: transfer occurs when tx_valid & tx_ready on a clock edge. tx_data is captured into the shift register; tx_ready goes low the next cycle.
  - uart_tx is registered. The start bit (0) appears on the cycle after the handshake.
  - Each bit is held exactly BIT_CYC cycles.
  - DATA sends DATA_BITS bits LSB first.
  - PAR is present only if PARITY != 0. It sends XOR of data (even) or its inverse (odd).
  - STOP holds 1 for STOP_BITS*BIT_CYC cycles, then goes to IDLE. tx_ready is 1 on the first IDLE cycle.
  - Total tx_ready-low time = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * BIT_CYC cycles.
  - Back-to-back: with tx_valid held high, the next start bit follows the last stop bit with exactly one idle-high cycle.
  - tx_valid while tx_ready=0 is ignored. tx_data changes during a frame have no effect.
- RX FSM states: IDLE, START, DATA, PAR, STOP.
  - rxs is the output of the last synchroniser stage.
  - IDLE: a 1->0 transition on rxs loads the counter and enters START.
  - START: samples rxs at count HALF.
    - If rxs=1 (glitch): go to IDLE, no output.
    - Otherwise: the counter restarts and subsequent samples are taken every BIT_CYC cycles.
  - DATA shifts samples in LSB first, DATA_BITS samples.
  - PAR samples the parity bit and computes the mismatch flag.
  - STOP samples STOP_BITS stop bits. frame_err = 1 if any stop sample is 0.
  - The cycle after the final stop-bit sample:
    - rx_valid=1 for one cycle.
    - rx_data, rx_parity_err and rx_frame_err update in that same cycle.
    - The FSM is in IDLE (mid-stop-bit), so a following start edge is caught.
  - Framing error (break / line held low): the frame is still delivered with rx_frame_err=1. The FSM returns to IDLE but arms only after rxs has been seen high, so no spurious frames occur while the line stays low.
  - rx_parity_err is always 0 when PARITY=0.
- RX and TX are fully independent. Simultaneous activity (loopback of uart_tx to uart_rx) must work.

Test Plan:
- Defaults overridden to CLK_FREQ=1_600_000, BAUD_RATE=100_000, 8N1 (BIT_CYC=16). tx_data=8'hA5 with one-cycle tx_valid -> uart_tx = 0,1,0,1,0,0,1,0,1,1, each 16 cycles; tx_ready low 160 cycles; uart_tx high afterwards.
- DATA_BITS=7, PARITY=2 (even), STOP_BITS=2, loopback uart_tx->uart_rx, send 7'h55 then 7'h03 back-to-back with tx_valid held -> frames 176 cycles + 1 idle cycle apart; two rx_valid pulses with rx_data 7'h55, 7'h03; both error flags 0.
- 8O1 receive, driven frame for 8'h00 with parity bit 0 -> rx_valid with rx_data=8'h00, rx_parity_err=1.
- 8N1, drive frame 8'hFF with stop bit 0, then line low for 40 bit times, then high -> exactly one rx_valid with rx_data=8'hFF, rx_frame_err=1; no further rx_valid until a new start edge.
- uart_rx low pulse of 5 cycles (< HALF=8) -> no rx_valid; a valid 8'h3C frame immediately after -> rx_valid with rx_data=8'h3C.
- Assert rst during the DATA state of TX and RX -> uart_tx=1 and tx_ready=1 within the reset; no rx_valid; a subsequent 8'h81 frame is sent and received correctly.
